// File: rtl/uart_string_tx.sv
// Serial transmit end of the CPU print path: sends the non-zero bytes of a
// 32-byte string as 8N1 frames (MSB byte first), optionally followed by CR LF.
module uart_string_tx #(
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned BAUD           = 115200,
  parameter bit          APPEND_NEWLINE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] uartData,
  input  logic         writeUart,
  output logic         uartWritten,
  output logic         uart_tx,
  output logic         busy
);

  localparam int unsigned DELAY_FRAMES = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           r_state,    w_state_next;
  logic [255:0]     r_data,     w_data_next;
  logic [5:0]       r_byte_idx, w_byte_idx_next;
  logic [7:0]       r_tx_byte,  w_tx_byte_next;
  logic [2:0]       r_bit_idx,  w_bit_idx_next;
  logic [CNT_W-1:0] r_clk_cnt,  w_clk_cnt_next;
  logic             r_tx,       w_tx_next;
  logic             r_written,  w_written_next;
  logic             w_cnt_last;
  logic [7:0]       w_cur_byte;

  assign w_cnt_last = (r_clk_cnt == CNT_LAST);
  // Holding register shifts left as bytes are consumed, so byte_idx's byte is always on top.
  assign w_cur_byte = r_data[255:248];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_byte_idx <= '0;
      r_tx_byte  <= '0;
      r_bit_idx  <= '0;
      r_clk_cnt  <= '0;
      r_tx       <= 1'b1;
      r_written  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_byte_idx <= w_byte_idx_next;
      r_tx_byte  <= w_tx_byte_next;
      r_bit_idx  <= w_bit_idx_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_tx       <= w_tx_next;
      r_written  <= w_written_next;
    end
  end

  // Line and acknowledge are registered from the current state, so they lag it by one cycle.
  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_byte_idx_next = r_byte_idx;
    w_tx_byte_next  = r_tx_byte;
    w_bit_idx_next  = r_bit_idx;
    w_clk_cnt_next  = r_clk_cnt;
    w_tx_next       = 1'b1;
    w_written_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (writeUart && !r_written) begin
          w_data_next     = uartData;
          w_byte_idx_next = '0;
          w_clk_cnt_next  = '0;
          w_state_next    = S_SCAN;
        end
      end

      S_SCAN: begin
        w_clk_cnt_next = '0;
        if (r_byte_idx < 6'd32) begin
          if (w_cur_byte == 8'h00) begin
            w_byte_idx_next = r_byte_idx + 6'd1;
            w_data_next     = {r_data[247:0], 8'h00};
          end else begin
            w_tx_byte_next = w_cur_byte;
            w_state_next   = S_START;
          end
        end else if (APPEND_NEWLINE && (r_byte_idx == 6'd32)) begin
          w_tx_byte_next = 8'h0D;
          w_state_next   = S_START;
        end else if (APPEND_NEWLINE && (r_byte_idx == 6'd33)) begin
          w_tx_byte_next = 8'h0A;
          w_state_next   = S_START;
        end else begin
          w_state_next = S_DONE;
        end
      end

      S_START: begin
        w_tx_next = 1'b0;
        if (w_cnt_last) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        w_tx_next = r_tx_byte[r_bit_idx];
        if (w_cnt_last) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (w_cnt_last) begin
          w_clk_cnt_next  = '0;
          w_byte_idx_next = r_byte_idx + 6'd1;
          w_data_next     = {r_data[247:0], 8'h00};
          w_state_next    = S_SCAN;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_written_next = 1'b1;
        if (!writeUart) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign uart_tx     = r_tx;
  assign uartWritten = r_written;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/uart_string_tx.md
Name: uart_string_tx

Overview:
- Serial transmit end of the CPU's print path.
- Accepts a 256-bit, 32-byte ASCII string from the CPU over a level request/acknowledge handshake: writeUart/uartData in, uartWritten out.
- Sends every non-zero byte on uart_tx as 8N1, most-significant byte first, with an optional CR LF at the end.
- Raises uartWritten when the string is done so the CPU can leave its UART wait state.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- APPEND_NEWLINE, 1, when 1 sends 0x0D then 0x0A after the string bytes.
- Derived localparam DELAY_FRAMES = CLK_HZ/BAUD (integer division). This is the number of clk cycles per bit, 234 at the defaults.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- uartData  input  256  string; byte k = uartData[255-8k -: 8], k=0..31. Byte 0 is sent first.
- writeUart  input  1  request, level; held high by the CPU until it sees uartWritten.
- uartWritten  output  1  acknowledge; string fully sent.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: uart_tx=1, uartWritten=0, busy=0, state=IDLE, all counters 0.
- Reset mid-frame forces uart_tx high on the next edge and abandons the string. The receiver may see a truncated frame.
- States: IDLE, SCAN, START, DATA, STOP, DONE.
- IDLE:
  - uart_tx=1.
  - If writeUart=1 and uartWritten=0: latch uartData into a 256-bit holding register, byte_idx=0, go to SCAN.
  - uartData is sampled only at this edge; later changes are ignored.
- SCAN, one cycle per byte examined:
  - If byte_idx<32 and the byte is 0x00: byte_idx+1, stay in SCAN. A zero byte costs exactly 1 cycle and is never transmitted.
  - If byte_idx<32 and the byte is non-zero: load it into tx_byte, go to START.
  - If byte_idx=32 and APPEND_NEWLINE=1: tx_byte=0x0D, go to START.
  - If byte_idx=33: tx_byte=0x0A, go to START.
  - Otherwise (index past the end of the string and any newline): go to DONE.
- START: uart_tx=0 for DELAY_FRAMES cycles, then go to DATA with bit_idx=0.
- DATA:
  - uart_tx = tx_byte[bit_idx], LSB first.
  - Each bit is held DELAY_FRAMES cycles; after bit 7, go to STOP.
- STOP: uart_tx=1 for DELAY_FRAMES cycles, then byte_idx+1 and go to SCAN.
- Frame timing: exactly 10*DELAY_FRAMES cycles per byte. There is no gap between consecutive bytes except 1 SCAN cycle, plus 1 cycle per skipped zero byte.
- Latency: the first start-bit edge of uart_tx appears 2+z cycles after the IDLE edge that sampled writeUart, where z is the number of leading zero bytes.
- DONE:
  - uartWritten=1, held while writeUart=1.
  - When writeUart=0 is sampled: uartWritten=0 and go to IDLE.
  - If writeUart is already low on entry, uartWritten is high for exactly 1 cycle.
- Re-trigger guard: IDLE does not start while uartWritten=1, so one request produces one transmission.
- writeUart falling mid-transmission is ignored; the string still completes.
- All-zero uartData with APPEND_NEWLINE=0: no frames are sent; 33 SCAN cycles, then DONE.
- All 32 bytes non-zero: all 32 are sent, plus CR LF when enabled.
- Bit and cycle counters are sized to hold DELAY_FRAMES-1 and do not wrap within a bit.

Test Plan:
- Bench parameters CLK_HZ=800, BAUD=100, giving DELAY_FRAMES=8.
- Reset check: assert reset for 3 cycles mid-frame -> next edge uart_tx=1, uartWritten=0, busy=0, state IDLE.
- Single byte, APPEND_NEWLINE=0: uartData={248'b0,"A"}, writeUart=1.
  - Bits 0,1,0,0,0,0,0,1,0,1 on uart_tx, each 8 cycles; 0x41 is LSB first.
  - Start-bit edge 2+31 cycles after the request.
  - uartWritten=1 until writeUart drops, then 0 the following cycle.
- "PRINT 0012" left-padded with zeros, APPEND_NEWLINE=1:
  - Decoded byte stream is exactly 50 52 49 4E 54 20 30 30 31 32 0D 0A.
  - Total frame time 12*80 cycles plus 34 SCAN cycles.
- Zero byte inside the string, e.g. "A",0x00,"B" at the end of uartData -> only 41 42 sent, with a 2-cycle SCAN gap between the frames.
- All-zero data, APPEND_NEWLINE=0 -> uart_tx stays high throughout; uartWritten rises 34 cycles after the request.
- Handshake:
  - writeUart dropped after 5 cycles -> the full string is still sent; uartWritten pulses 1 cycle; IDLE follows.
  - writeUart held high after the ack -> no second transmission until writeUart goes low and then high again.
